// File: rtl/eth_pkt_pkg.sv
// Shared types and constants for the switch-port packet transmitter.
// Header words are selected by index so the framing order lives in one place.
package eth_pkt_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, DST, SRC, PLD, GAP} tx_state_t;

    localparam logic W_DST = 1'b0;
    localparam logic W_SRC = 1'b1;

    localparam logic [31:0] PORTA_ADDR = 32'h0000_A000;
    localparam logic [31:0] PORTB_ADDR = 32'h0000_B000;

    function automatic logic [31:0] hdr_word(input logic idx, input logic [31:0] dst,
                                             input logic [31:0] src);
        return (idx == W_DST) ? dst : src;
    endfunction

endpackage

// File: rtl/eth_tx_pld_buf.sv
// First-word-fall-through payload FIFO: head always shows the oldest word.
// Pushes while full are dropped; pops on an empty buffer are ignored.
module eth_tx_pld_buf #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    output logic [31:0]      head,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/eth_pkt_tx.sv
// Frames buffered payload into gapless sop/eop packets for one switch input port.
// The state names the word currently held in the output register (DST, SRC, PLD).
module eth_pkt_tx
    import eth_pkt_pkg::*;
#(
    parameter logic [31:0] SRC_ADDR = 32'hABCD,
    parameter int          MAX_LEN  = 16,
    parameter int          IPG      = 1,
    parameter int          LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [31:0]      desc_dst,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             pld_valid,
    output logic             pld_ready,
    input  logic [31:0]      pld_data,
    input  logic             tx_stall,
    output logic [31:0]      outData,
    output logic             sopO,
    output logic             eopO,
    output logic             tx_busy,
    output logic             err_len,
    output logic [15:0]      pkt_cnt
);
    tx_state_t        state_q, state_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [3:0]       gap_q, gap_d;
    logic [31:0]      out_q, out_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             err_q, err_d;
    logic             busy_q;
    logic [15:0]      pkt_cnt_q;
    logic             pop;
    logic [31:0]      buf_head;
    logic             buf_full;
    logic [LEN_W-1:0] buf_count;

    eth_tx_pld_buf #(.DEPTH(MAX_LEN), .CNT_W(LEN_W)) u_buf (
        .clk       (clk),
        .rstN      (rstN),
        .push      (pld_valid),
        .push_data (pld_data),
        .pop       (pop),
        .head      (buf_head),
        .full      (buf_full),
        .count     (buf_count)
    );

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        len_d   = len_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        out_d   = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (desc_valid) begin
                if (desc_len == '0 || desc_len > LEN_W'(MAX_LEN)) begin
                    err_d = 1'b1;
                end else begin
                    dst_d   = desc_dst;
                    len_d   = desc_len;
                    state_d = WAIT;
                end
            end
            // Start only with the whole payload buffered, so the packet cannot gap.
            WAIT: if (buf_count >= len_q && !tx_stall) begin
                out_d   = hdr_word(W_DST, dst_q, SRC_ADDR);
                sop_d   = 1'b1;
                state_d = DST;
            end
            DST: begin
                out_d   = hdr_word(W_SRC, dst_q, SRC_ADDR);
                state_d = SRC;
            end
            SRC: begin
                pop     = 1'b1;
                out_d   = buf_head;
                eop_d   = (len_q == LEN_W'(1));
                rem_d   = len_q - 1'b1;
                state_d = PLD;
            end
            PLD: if (rem_q != '0) begin
                pop   = 1'b1;
                out_d = buf_head;
                eop_d = (rem_q == LEN_W'(1));
                rem_d = rem_q - 1'b1;
            end else if (IPG == 0) begin
                state_d = IDLE;
            end else begin
                gap_d   = 4'(IPG - 1);
                state_d = GAP;
            end
            GAP: if (gap_q == '0) state_d = IDLE;
                 else gap_d = gap_q - 4'd1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            out_q     <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            out_q     <= out_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            pkt_cnt_q <= pkt_cnt_q + 16'(eop_d);
        end
    end

    assign desc_ready = (state_q == IDLE);
    assign pld_ready  = !buf_full;
    assign outData    = out_q;
    assign sopO       = sop_q;
    assign eopO       = eop_q;
    assign tx_busy    = busy_q;
    assign err_len    = err_q;
    assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_eth_pkt_tx.sv
// Scoreboard bench: drivers log descriptors and accepted payload words; a negedge
// monitor frames the expected packet from that log whenever the DUT raises sopO.
module tb_eth_pkt_tx;
    import eth_pkt_pkg::*;

    localparam logic [31:0] SRC_ADDR = 32'hABCD;
    localparam int          MAX_LEN  = 16;
    localparam int          IPG      = 1;
    localparam int          LEN_W    = $clog2(MAX_LEN + 1);
    localparam int          BOUND    = 3000;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             desc_valid = 1'b0;
    logic             desc_ready;
    logic [31:0]      desc_dst = '0;
    logic [LEN_W-1:0] desc_len = '0;
    logic             pld_valid = 1'b0;
    logic             pld_ready;
    logic [31:0]      pld_data = '0;
    logic             tx_stall = 1'b0;
    logic [31:0]      outData;
    logic             sopO;
    logic             eopO;
    logic             tx_busy;
    logic             err_len;
    logic [15:0]      pkt_cnt;

    eth_pkt_tx #(.SRC_ADDR(SRC_ADDR), .MAX_LEN(MAX_LEN), .IPG(IPG)) dut (
        .clk(clk), .rstN(rstN),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dst(desc_dst), .desc_len(desc_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .tx_stall(tx_stall), .outData(outData), .sopO(sopO), .eopO(eopO),
        .tx_busy(tx_busy), .err_len(err_len), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] dst; int len; int hs; int exp_sop; } desc_t;
    typedef struct { logic [31:0] data; logic sop; logic eop; } word_t;

    desc_t       sb_desc[$];
    word_t       exp_words[$];
    logic [31:0] pld_model[$];
    int          err_q[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    bit          in_pkt = 1'b0;
    int          last_eop = -1;
    int          exp_cnt = 0;
    bit          rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: frames each packet from the descriptor and payload logs at sopO.
    always @(negedge clk) begin : mon
        desc_t d;
        word_t w;
        if (!rstN) begin
            in_pkt   = 1'b0;
            exp_words.delete();
            exp_cnt  = 0;
            last_eop = -1;
        end else begin
            if (!in_pkt && sopO) begin
                if (sb_desc.size() == 0) begin
                    chk("unexpected_sop", 1'b1, 1'b0);
                end else begin
                    d = sb_desc.pop_front();
                    w.data = d.dst;    w.sop = 1'b1; w.eop = 1'b0; exp_words.push_back(w);
                    w.data = SRC_ADDR; w.sop = 1'b0; exp_words.push_back(w);
                    for (int i = 0; i < d.len; i++) begin
                        if (pld_model.size() == 0) begin
                            chk("payload_underrun", 1'b1, 1'b0);
                            w.data = '0;
                        end else begin
                            w.data = pld_model.pop_front();
                        end
                        w.eop = (i == d.len - 1);
                        exp_words.push_back(w);
                    end
                    if (d.exp_sop >= 0) chk("sop_latency", cyc, d.exp_sop);
                    chk("sop_not_early", (cyc >= d.hs + 2), 1'b1);
                    if (last_eop >= 0) chk("ipg_min", (cyc - last_eop - 1 >= IPG), 1'b1);
                    in_pkt = 1'b1;
                end
            end
            if (in_pkt) begin
                w = exp_words.pop_front();
                chk("pkt_data", outData, w.data);
                chk("pkt_sop", sopO, w.sop);
                chk("pkt_eop", eopO, w.eop);
                if (w.eop) begin
                    in_pkt   = 1'b0;
                    last_eop = cyc;
                    exp_cnt++;
                    chk("pkt_cnt", pkt_cnt, 32'(16'(exp_cnt)));
                end
            end else begin
                chk("idle_data", outData, '0);
                chk("idle_eop", eopO, 1'b0);
            end
            if (err_len) begin
                if (err_q.size() == 0) chk("unexpected_err_len", 1'b1, 1'b0);
                else chk("err_len_cycle", cyc, err_q.pop_front());
                chk("err_desc_ready", desc_ready, 1'b1);
                chk("err_pkt_cnt", pkt_cnt, 32'(16'(exp_cnt)));
            end
        end
    end

    task automatic push_word(input logic [31:0] d, output int c);
        int n = 0;
        @(negedge clk);
        pld_valid = 1'b1;
        pld_data  = d;
        while (!pld_ready && n < BOUND) begin @(negedge clk); n++; end
        c = cyc;
        if (!pld_ready) chk("push_timeout", 1'b0, 1'b1);
        else pld_model.push_back(d);
        @(negedge clk);
        pld_valid = 1'b0;
    endtask

    task automatic send_desc(input logic [31:0] dst, input int len, input bit fast);
        int n = 0;
        desc_t d;
        @(negedge clk);
        desc_valid = 1'b1;
        desc_dst   = dst;
        desc_len   = LEN_W'(len);
        while (!desc_ready && n < BOUND) begin @(negedge clk); n++; end
        if (!desc_ready) begin
            chk("desc_timeout", 1'b0, 1'b1);
        end else if (len >= 1 && len <= MAX_LEN) begin
            d.dst = dst; d.len = len; d.hs = cyc; d.exp_sop = fast ? cyc + 2 : -1;
            sb_desc.push_back(d);
        end else begin
            err_q.push_back(cyc + 1);
        end
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((sb_desc.size() != 0 || in_pkt || tx_busy) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", (n < BOUND), 1'b1);
    endtask

    task automatic wait_sop();
        int n = 0;
        while (!sopO && n < BOUND) begin @(negedge clk); n++; end
        chk("sop_seen", sopO, 1'b1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
        $fatal(1);
    end

    initial begin : stim
        int c;
        int lens[12];
        int tot;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("rst_desc_ready", desc_ready, 1'b1);
        chk("rst_pld_ready", pld_ready, 1'b1);
        chk("rst_outData", outData, '0);
        chk("rst_sop", sopO, 1'b0);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_err", err_len, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, '0);

        // Basic framing with payload preloaded
        push_word(32'hA1, c); push_word(32'hB2, c); push_word(32'hC3, c);
        send_desc(32'h1234, 3, 1'b1);
        wait_idle();
        chk("basic_pkt_cnt", pkt_cnt, 32'd1);

        // Stall holds the start; a stall inside the packet is ignored
        push_word(32'h11, c); push_word(32'h22, c); push_word(32'h33, c);
        tx_stall = 1'b1;
        send_desc(PORTA_ADDR, 3, 1'b0);
        repeat (10) begin @(negedge clk); chk("stall_no_sop", sopO, 1'b0); end
        @(negedge clk);
        tx_stall = 1'b0;
        if (sb_desc.size() != 0) sb_desc[0].exp_sop = cyc + 1;
        wait_sop();
        @(negedge clk);
        tx_stall = 1'b1;
        wait_idle();
        tx_stall = 1'b0;

        // Illegal lengths are dropped with an err_len pulse each
        send_desc(PORTB_ADDR, 0, 1'b0);
        send_desc(PORTB_ADDR, MAX_LEN + 1, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_all_seen", err_q.size(), 0);
        chk("err_pkt_cnt_same", pkt_cnt, 32'd2);

        // Back-to-back single-word packets
        push_word(32'h5A5A_0001, c); push_word(32'h5A5A_0002, c);
        send_desc(PORTA_ADDR, 1, 1'b1);
        send_desc(PORTB_ADDR, 1, 1'b0);
        wait_idle();

        // Descriptor ahead of its payload waits in WAIT
        push_word(32'hD1, c); push_word(32'hD2, c);
        send_desc(32'hCAFE, 4, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("wait_busy", tx_busy, 1'b1);
            chk("wait_no_sop", sopO, 1'b0);
        end
        push_word(32'hD3, c);
        push_word(32'hD4, c);
        if (sb_desc.size() != 0) sb_desc[0].exp_sop = c + 2;
        wait_idle();

        // Randomised traffic: concurrent payload, descriptors and stall
        tot = 3;
        foreach (lens[i]) begin
            if ($urandom_range(0, 6) == 0)
                lens[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 31));
            else
                lens[i] = int'($urandom_range(1, MAX_LEN));
            if (lens[i] >= 1 && lens[i] <= MAX_LEN) tot += lens[i];
        end
        fork
            begin
                fork
                    begin
                        int pc;
                        for (int i = 0; i < tot; i++) begin
                            repeat ($urandom_range(0, 2)) @(negedge clk);
                            push_word($urandom, pc);
                        end
                    end
                    begin
                        for (int i = 0; i < 12; i++) begin
                            repeat ($urandom_range(0, 8)) @(negedge clk);
                            send_desc($urandom, lens[i], 1'b0);
                        end
                    end
                join
                wait_idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    tx_stall = ($urandom_range(0, 3) == 0);
                end
                tx_stall = 1'b0;
            end
        join
        chk("rnd_err_all_seen", err_q.size(), 0);
        chk("rnd_desc_all_sent", sb_desc.size(), 0);

        // Reset mid-packet: three leftover words feed this packet
        send_desc(PORTB_ADDR, 3, 1'b1);
        wait_sop();
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("midrst_outData", outData, '0);
        chk("midrst_sop", sopO, 1'b0);
        chk("midrst_eop", eopO, 1'b0);
        chk("midrst_pkt_cnt", pkt_cnt, '0);
        sb_desc.delete();
        pld_model.delete();
        err_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        chk("postrst_desc_ready", desc_ready, 1'b1);
        chk("postrst_pld_ready", pld_ready, 1'b1);

        // Buffer was flushed: the next packet carries only the new word
        push_word(32'hF00D, c);
        send_desc(PORTA_ADDR, 1, 1'b1);
        wait_idle();
        chk("postrst_pkt_cnt", pkt_cnt, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
